// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder, purely combinational. The serial controller
// steps one instance of it across the operand bits.
module FA (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : FA

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in
// by clocking one full adder LSB first for WIDTH cycles, then pulses done
// with registered sum, carry-out and signed-overflow results.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Counter holds 0..WIDTH, so it can never wrap inside one operation.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic fa_sum;
    logic fa_carry;

    FA u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Result shift register after this bit: new sum bit enters at the MSB.
    always_comb begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_sum;
    end

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    res_q   <= res_d;
                    carry_q <= fa_carry;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q still holds the carry into the MSB here
                        sum_q   <= res_d;
                        cout_q  <= fa_carry;
                        ovf_q   <= carry_q ^ fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Last result the DUT should be holding on sum/cout/ovf.
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic, unsigned for sum/cout, signed for ovf.
    task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int u;
        int s;
        u  = int'(oa) + int'(ob) + int'(oc);
        s  = int'($signed(oa)) + int'($signed(ob)) + int'(oc);
        es = W'(u % 256);
        ec = (u >= 256);
        eo = (s > 127) || (s < -128);
    endtask

    // Runs one addition starting from IDLE at a negedge. If inj is 1..7,
    // a spurious start with other operands is pulsed after bit edge inj.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc, input int inj);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        model(oa, ob, oc, es, ec, eo);
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after acceptance; result must not care.
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(ready), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check("done_during_add", 32'(done), 32'd0);
            check("sum_held_during_add", 32'(sum), 32'(prev_sum));
            check("cout_held_during_add", 32'(cout), 32'(prev_cout));
            if (i == inj) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_back", 32'(ready), 32'd1);
        @(negedge clk);
        check("no_second_op", 32'(ready), 32'd1);
        check("no_second_done", 32'(done), 32'd0);
        prev_sum = es; prev_cout = ec; prev_ovf = eo;
        $display("op a=0x%02h b=0x%02h cin=%0d inj=%0d -> sum=0x%02h cout=%0d ovf=%0d (exp 0x%02h %0d %0d)",
                 oa, ob, oc, inj, sum, cout, ovf, es, ec, eo);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int waited;
        logic seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(8'h5A, 8'h3C, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'h7F, 8'h00, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 3);

        // Reset in the middle of 0xAA + 0x55
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout_ovf", 32'({cout, ovf}), 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        rst = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        $display("reset mid-op of 0xAA+0x55 applied");
        run_op(8'h01, 8'h01, 1'b0, 0);

        // Randomized operations, some with a spurious start while busy
        for (int n = 0; n < 20; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0);
        end

        // Back-to-back: start held high, done pulses every WIDTH+2 cycles
        start = 1'b1; a = 8'h21; b = 8'h13; cin = 1'b0;
        done_cnt = 0; last_done = 0;
        for (int cyc = 1; cyc <= 42; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (last_done != 0) check("b2b_spacing", 32'(cyc - last_done), 32'd10);
                else check("b2b_first_latency", 32'(cyc), 32'd9);
                check("b2b_sum", 32'(sum), 32'h34);
                last_done = cyc;
            end
        end
        check("b2b_done_count", 32'(done_cnt), 32'd4);
        $display("back-to-back: %0d done pulses, last at cycle %0d", done_cnt, last_done);
        start = 1'b0;
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("b2b_drain_ready", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin one addition; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 ready  output  1  high in IDLE only; start is accepted when ready=1.
REQ-009 busy  output  1  high in ADD state.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 sum  output  WIDTH  registered result, held until the next result is written.
REQ-012 cout  output  1  registered final carry-out.
REQ-013 ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The block shall sequence one single-bit full adder serially, LSB first, over WIDTH cycles.
REQ-015 FSM states shall be IDLE, ADD and DONE.
- IDLE->ADD on start=1.
- ADD->DONE after the WIDTH-th bit edge.
- DONE->IDLE unconditionally after one cycle.
REQ-016 Accepting start at edge E0 shall load the a/b shift registers and the carry flop with cin, clear the bit counter, and set busy.
REQ-017 At each edge E1..EWIDTH:
- the full adder shall consume the LSBs of the a/b shift registers and the carry flop;
- its sum bit shall shift into the MSB of the result shift register;
- its carry shall update the carry flop;
- the a/b registers shall shift right by one;
- the counter shall increment.
REQ-018 At the edge where the counter completes WIDTH bits (EWIDTH):
- sum, cout and ovf shall update;
- the state shall become DONE, so done=1 during the cycle following EWIDTH.
REQ-019 Latency shall be fixed: done is high exactly WIDTH+1 cycles after the cycle in which start was sampled, independent of operand values.
REQ-020 The block shall capture the carry into the MSB (carry flop value before the final bit) to form ovf.
REQ-021 start while busy=1 or in DONE shall be ignored, with no effect on the operation in progress or on outputs.
REQ-022 Operand inputs a, b and cin may change after the accepting edge without affecting the result.
REQ-023 sum/cout/ovf shall remain stable from EWIDTH until the EWIDTH of the next operation; they shall not change during ADD.
REQ-024 The bit counter shall be $clog2(WIDTH+1) bits wide and shall never wrap within an operation.
REQ-025 The result shall equal (a + b + cin) mod 2^WIDTH, with cout the bit-WIDTH carry.

Reset
REQ-026 On rst=1 the block shall immediately, without a clock:
- enter IDLE;
- set ready=1, busy=0, done=0;
- set sum=0, cout=0, ovf=0;
- clear the shift registers, carry flop and counter.
REQ-027 Reset asserted mid-ADD shall abandon the operation; no done pulse shall follow.
REQ-028 The first start shall be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 Package serial_add_pkg shall hold the FSM state encoding (IDLE/ADD/DONE) and the default WIDTH constant.
REQ-030 The single-bit adder shall be the team's existing full-adder module FA (ports a, b, c, sum, carry), instantiated once as the only sub-module.
REQ-031 All state shall be in serial_add_ctrl; FA stays purely combinational.

Verification (WIDTH=8)
REQ-032 Signed overflow: a=0x5A, b=0x3C, cin=0, start -> after 9 cycles done=1, sum=0x96, cout=0, ovf=1.
REQ-033 Unsigned wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-034 Carry-in path: a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1.
REQ-035 Start while busy: start pulsed at bit 3 of an add of 0x12+0x34 with different a/b -> result 0x46, exactly one done pulse, second start ignored.
REQ-036 Reset mid-operation: rst asserted after bit 4 of 0xAA+0x55 -> all outputs 0 and ready=1 immediately, no done; the next start of 0x01+0x01 -> sum=0x02.
REQ-037 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles, done pulses spaced 10 cycles apart.
